// File: rtl/lcd_i2c_byte_writer.sv
// lcd_i2c_byte_writer
//   Writes one HD44780 byte (4-bit mode) through a PCF8574 I2C backpack.
//   The byte is split into two nibbles. Each nibble is sent twice, first with
//   EN high and then with EN low. All four expander bytes go out in a single
//   write frame: START, addr+W, 4 data bytes, STOP.
//   The bit-level open-drain I2C master is built in. It has no clock
//   stretching, no arbitration and no repeated START.
// Ports
//   clk_1MHz   : sole clock
//   rst_n      : asynchronous active-low reset; releases the bus immediately
//   ena_write  : request pulse; data/cmd_data/backlight sampled when accepted
//   data       : LCD byte
//   cmd_data   : RS flag (0 = command, 1 = character)
//   backlight  : expander P3
//   done_write : one-cycle pulse at end of every accepted frame (NACK included)
//   busy       : frame in progress (low again in the done_write cycle)
//   ack_error  : sticky NACK flag, cleared on the next accepted request
//   scl_oe     : 1 = pull SCL low
//   sda_oe     : 1 = pull SDA low
//   sda_in     : SDA pin level
module lcd_i2c_byte_writer #(
    parameter logic [6:0]  I2C_ADDR = 7'h27,
    parameter int unsigned QDIV     = 3
) (
    input  logic       clk_1MHz,
    input  logic       rst_n,
    input  logic       ena_write,
    input  logic [7:0] data,
    input  logic       cmd_data,
    input  logic       backlight,
    output logic       done_write,
    output logic       busy,
    output logic       ack_error,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_in
);

    localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StBit,
        StAck,
        StStop,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [QW-1:0]   qcnt_q, qcnt_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [7:0]      data_q, data_d;
    logic            rs_q, rs_d;
    logic            bl_q, bl_d;
    logic            ack_error_q, ack_error_d;
    logic            sda_meta_q, sda_sync_q;

    logic            q_end;
    logic            phase_end;
    logic [7:0]      cur_byte;
    logic            cur_bit;

    // Byte idx of the frame: 0 = address, 1..4 = hi/EN, hi, lo/EN, lo.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] d,
                                              input logic rs, input logic bl);
        logic [7:0] b;
        case (idx)
            3'd1:    b = {d[7:4], bl, 1'b1, 1'b0, rs};
            3'd2:    b = {d[7:4], bl, 1'b0, 1'b0, rs};
            3'd3:    b = {d[3:0], bl, 1'b1, 1'b0, rs};
            3'd4:    b = {d[3:0], bl, 1'b0, 1'b0, rs};
            default: b = {I2C_ADDR, 1'b0};
        endcase
        return b;
    endfunction

    assign q_end     = (qcnt_q == QLAST);
    assign phase_end = q_end && (quarter_q == 2'd3);
    assign cur_byte  = frame_byte(byte_idx_q, data_q, rs_q, bl_q);
    assign cur_bit   = cur_byte[bit_idx_q];

    always_comb begin
        state_d     = state_q;
        qcnt_d      = qcnt_q;
        quarter_d   = quarter_q;
        bit_idx_d   = bit_idx_q;
        byte_idx_d  = byte_idx_q;
        data_d      = data_q;
        rs_d        = rs_q;
        bl_d        = bl_q;
        ack_error_d = ack_error_q;

        // Quarter timing runs in every bus phase; each phase spans exactly 4 quarters.
        if (state_q inside {StStart, StBit, StAck, StStop}) begin
            if (q_end) begin
                qcnt_d    = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                qcnt_d = qcnt_q + QW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (ena_write) begin
                    state_d     = StStart;
                    qcnt_d      = '0;
                    quarter_d   = 2'd0;
                    bit_idx_d   = 3'd7;
                    byte_idx_d  = 3'd0;
                    data_d      = data;
                    rs_d        = cmd_data;
                    bl_d        = backlight;
                    ack_error_d = 1'b0;
                end
            end
            StStart: begin
                if (phase_end) begin
                    state_d   = StBit;
                    bit_idx_d = 3'd7;
                end
            end
            StBit: begin
                if (phase_end) begin
                    if (bit_idx_q == 3'd0) begin
                        state_d = StAck;
                    end else begin
                        bit_idx_d = bit_idx_q - 3'd1;
                    end
                end
            end
            StAck: begin
                if (phase_end) begin
                    if (sda_sync_q) begin
                        ack_error_d = 1'b1;
                        state_d     = StStop;
                    end else if (byte_idx_q == 3'd4) begin
                        state_d = StStop;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        bit_idx_d  = 3'd7;
                        state_d    = StBit;
                    end
                end
            end
            StStop: begin
                if (phase_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            qcnt_q      <= '0;
            quarter_q   <= 2'd0;
            bit_idx_q   <= 3'd7;
            byte_idx_q  <= 3'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            bl_q        <= 1'b0;
            ack_error_q <= 1'b0;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quarter_q   <= quarter_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            data_q      <= data_d;
            rs_q        <= rs_d;
            bl_q        <= bl_d;
            ack_error_q <= ack_error_d;
            // The slave drives ACK from the SCL-low half, so the two-flop delay still
            // lands inside the ACK phase when it is sampled at the end of Q3.
            sda_meta_q  <= sda_in;
            sda_sync_q  <= sda_meta_q;
        end
    end

    // Bus drive is decoded from state so reset releases both lines at once.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            StStart: begin
                sda_oe = quarter_q[1];
            end
            StBit: begin
                scl_oe = ~quarter_q[1];
                sda_oe = ~cur_bit;
            end
            StAck: begin
                scl_oe = ~quarter_q[1];
            end
            StStop: begin
                scl_oe = (quarter_q == 2'd0);
                sda_oe = ~quarter_q[1];
            end
            default: begin
                scl_oe = 1'b0;
                sda_oe = 1'b0;
            end
        endcase
    end

    assign done_write = (state_q == StDone);
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign ack_error  = ack_error_q;

endmodule

// File: tb/tb_lcd_i2c_byte_writer.sv
module tb_lcd_i2c_byte_writer;

    localparam int unsigned QDIV  = 3;
    localparam logic [6:0]  ADDR  = 7'h27;
    localparam int          LIMIT = 2000;

    logic       clk_1MHz = 1'b0;
    logic       rst_n;
    logic       ena_write;
    logic [7:0] data;
    logic       cmd_data;
    logic       backlight;
    logic       done_write;
    logic       busy;
    logic       ack_error;
    logic       scl_oe;
    logic       sda_oe;
    logic       sda_in;
    logic       slave_pull;

    int tests_run    = 0;
    int tests_failed = 0;

    // Slave / bus monitor state
    logic [7:0] exp_q[$];
    int         cfg_nack_at  = -1;
    bit         cfg_no_slave = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    bit         in_frame = 1'b0;
    int         bitcnt   = 0;
    int         rx_idx   = 0;
    logic [7:0] rx_byte  = 8'h00;
    int         start_cnt = 0;
    int         stop_cnt  = 0;

    assign sda_in = ~(sda_oe | slave_pull);

    always #5 clk_1MHz = ~clk_1MHz;

    lcd_i2c_byte_writer #(
        .I2C_ADDR (ADDR),
        .QDIV     (QDIV)
    ) dut (
        .clk_1MHz   (clk_1MHz),
        .rst_n      (rst_n),
        .ena_write  (ena_write),
        .data       (data),
        .cmd_data   (cmd_data),
        .backlight  (backlight),
        .done_write (done_write),
        .busy       (busy),
        .ack_error  (ack_error),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_in     (sda_in)
    );

    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] d, input logic rs,
                                            input logic bl);
        logic [3:0] nib;
        logic       en;
        if (i == 0) return {ADDR, 1'b0};
        nib = (i < 3) ? d[7:4] : d[3:0];
        en  = (i % 2) == 1;
        return {nib, bl, en, 1'b0, rs};
    endfunction

    // One sample of the open-drain bus; acts as slave and checks received bytes.
    task automatic bus_step();
        logic scl;
        logic sda;
        logic [7:0] e;
        scl = ~scl_oe;
        sda = sda_in;
        if (!rst_n) begin
            in_frame   = 1'b0;
            bitcnt     = 0;
            slave_pull = 1'b0;
            scl        = 1'b1;
            sda        = 1'b1;
        end else if (prev_scl && scl && prev_sda && !sda) begin
            start_cnt++;
            in_frame = 1'b1;
            bitcnt   = 0;
            rx_idx   = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            stop_cnt++;
            in_frame = 1'b0;
            bitcnt   = 0;
        end else if (!prev_scl && scl && in_frame) begin
            if (bitcnt < 8) begin
                rx_byte = {rx_byte[6:0], sda};
                bitcnt++;
                if (bitcnt == 8) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_byte: got %02h, expected no byte", rx_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (rx_byte !== e) begin
                            tests_failed++;
                            $display("FAIL sda_byte%0d: got %02h, expected %02h",
                                     rx_idx, rx_byte, e);
                        end
                    end
                end
            end else begin
                bitcnt = 9;
            end
        end else if (prev_scl && !scl && in_frame) begin
            if (bitcnt == 8) begin
                slave_pull = !cfg_no_slave && (rx_idx != cfg_nack_at);
            end else if (bitcnt == 9) begin
                slave_pull = 1'b0;
                bitcnt     = 0;
                rx_idx++;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
    endtask

    task automatic tick();
        @(posedge clk_1MHz);
        #1;
        bus_step();
    endtask

    // Runs one request end to end and checks latency, flags and bus framing.
    task automatic run_frame(input logic [7:0] d, input logic rs, input logic bl,
                             input int nack_at, input bit no_slave, input int nbytes,
                             input int exp_lat, input logic exp_err, input int poke_at,
                             input bit poke_done);
        int n;
        bit got;
        int s0;
        int p0;
        for (int i = 0; i < nbytes; i++) exp_q.push_back(exp_byte(i, d, rs, bl));
        cfg_nack_at  = nack_at;
        cfg_no_slave = no_slave;
        s0 = start_cnt;
        p0 = stop_cnt;
        data      = d;
        cmd_data  = rs;
        backlight = bl;
        ena_write = 1'b1;
        tick();
        ena_write = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_after_accept: got %b, expected 1", busy);
        end
        tests_run++;
        if (ack_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_error_clear_on_accept: got %b, expected 0", ack_error);
        end
        n   = 0;
        got = 1'b0;
        while (n < LIMIT) begin
            tick();
            n++;
            if (done_write === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (n == poke_at) begin
                ena_write = 1'b1;
                data      = ~d;
                cmd_data  = ~rs;
            end else begin
                ena_write = 1'b0;
                data      = d;
                cmd_data  = rs;
            end
        end
        ena_write = 1'b0;
        tests_run++;
        if (!got) begin
            tests_failed++;
            $display("FAIL done_timeout: got no done_write in %0d cycles, expected %0d",
                     LIMIT, exp_lat);
        end
        tests_run++;
        if (n != exp_lat) begin
            tests_failed++;
            $display("FAIL done_latency: got %0d cycles, expected %0d", n, exp_lat);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_at_done: got %b, expected 0", busy);
        end
        tests_run++;
        if (ack_error !== exp_err) begin
            tests_failed++;
            $display("FAIL ack_error: got %b, expected %b", ack_error, exp_err);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL missing_bytes: got %0d left over, expected 0", exp_q.size());
            exp_q.delete();
        end
        tests_run++;
        if (start_cnt - s0 != 1) begin
            tests_failed++;
            $display("FAIL start_count: got %0d, expected 1", start_cnt - s0);
        end
        tests_run++;
        if (stop_cnt - p0 != 1) begin
            tests_failed++;
            $display("FAIL stop_count: got %0d, expected 1", stop_cnt - p0);
        end
        if (poke_done) ena_write = 1'b1;
        tick();
        ena_write = 1'b0;
        tests_run++;
        if (done_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_one_cycle: got %b, expected 0", done_write);
        end
        if (poke_done) begin
            for (int i = 0; i < 20; i++) begin
                tick();
                tests_run++;
                if (busy !== 1'b0 || done_write !== 1'b0 || scl_oe !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL ignored_request: got busy=%b done=%b scl_oe=%b, expected 0 0 0",
                             busy, done_write, scl_oe);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ena_write  = 1'b0;
        data       = 8'h00;
        cmd_data   = 1'b0;
        backlight  = 1'b0;
        slave_pull = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({scl_oe, sda_oe, busy, done_write, ack_error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got scl=%b sda=%b busy=%b done=%b err=%b, expected all 0",
                     scl_oe, sda_oe, busy, done_write, ack_error);
        end
        rst_n = 1'b1;
        repeat (3) tick();
        // Start a frame, then reset it partway through the address byte.
        data      = 8'h41;
        cmd_data  = 1'b1;
        backlight = 1'b1;
        ena_write = 1'b1;
        tick();
        ena_write = 1'b0;
        repeat (60) tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_mid_frame: got %b, expected 1", busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({scl_oe, sda_oe, busy} !== 3'b000) begin
            tests_failed++;
            $display("FAIL async_reset: got scl=%b sda=%b busy=%b, expected 0 0 0",
                     scl_oe, sda_oe, busy);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        exp_q.delete();
        repeat (3) tick();
    endtask

    task automatic test_char_write();
        run_frame(8'h41, 1'b1, 1'b1, -1, 1'b0, 5, 188 * QDIV, 1'b0, -1, 1'b0);
    endtask

    task automatic test_cmd_write();
        run_frame(8'h01, 1'b0, 1'b1, -1, 1'b0, 5, 188 * QDIV, 1'b0, -1, 1'b0);
    endtask

    task automatic test_no_slave();
        run_frame(8'h5A, 1'b1, 1'b0, -1, 1'b1, 1, 44 * QDIV, 1'b1, -1, 1'b0);
        run_frame(8'hA5, 1'b0, 1'b0, -1, 1'b0, 5, 188 * QDIV, 1'b0, -1, 1'b0);
    endtask

    task automatic test_data_nack();
        run_frame(8'hC3, 1'b1, 1'b1, 2, 1'b0, 3, 116 * QDIV, 1'b1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_frame(8'h7E, 1'b1, 1'b1, -1, 1'b0, 5, 188 * QDIV, 1'b0, 50, 1'b1);
        run_frame(8'h38, 1'b0, 1'b0, -1, 1'b0, 5, 188 * QDIV, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_char_write();
        test_cmd_write();
        test_no_slave();
        test_data_nack();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
